// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one external multiplier among NREQ requesters, one op at a time.
// Optional build macro MUL_ARB_OVF_EN: when defined, resp_ovf reports the captured mul_overflow.
module mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_op1,
    input  logic [32*NREQ-1:0] req_op2,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [64:0]        resp_res,
    output logic               resp_ovf,
    output logic               mul_en,
    output logic [31:0]        mul_op1,
    output logic [31:0]        mul_op2,
    input  logic [64:0]        mul_res,
    input  logic               mul_val,
    input  logic               mul_overflow
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           err;

    // Search starts at the pointer so the most recently served requester goes last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        ptr_nxt = IDW'((int'(grant_idx) + 1) % NREQ);
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        mul_en     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = ISSUE;
                end
            end
            ISSUE: begin
                mul_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            mul_op1  <= '0;
            mul_op2  <= '0;
            resp_id  <= '0;
            resp_res <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_found) begin
                mul_op1 <= req_op1[32*grant_idx +: 32];
                mul_op2 <= req_op2[32*grant_idx +: 32];
                resp_id <= grant_idx;
                ptr     <= ptr_nxt;
            end
            if (state == CAPT) begin
                resp_res <= mul_res;
                if (!mul_val) err <= 1'b1;
            end
        end
    end

`ifdef MUL_ARB_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             resp_ovf <= 1'b0;
        else if (state == CAPT) resp_ovf <= mul_overflow;
    end

    logic unused_sig;
    assign unused_sig = err;
`else
    assign resp_ovf = 1'b0;

    // err is a sticky simulation-only flag; mul_overflow has no consumer in this build.
    logic unused_sig;
    assign unused_sig = err ^ mul_overflow;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a two-cycle multiplier model behind it.
module tb_mul_arbiter;

    localparam int NREQ = 4;
`ifdef MUL_ARB_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_op1;
    logic [32*NREQ-1:0] req_op2;
    logic               resp_valid;
    logic               resp_ready;
    logic [1:0]         resp_id;
    logic [64:0]        resp_res;
    logic               resp_ovf;
    logic               mul_en;
    logic [31:0]        mul_op1;
    logic [31:0]        mul_op2;
    logic [64:0]        mul_res;
    logic               mul_val;
    logic               mul_overflow;

    mul_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_res(resp_res), .resp_ovf(resp_ovf),
        .mul_en(mul_en), .mul_op1(mul_op1), .mul_op2(mul_op2),
        .mul_res(mul_res), .mul_val(mul_val), .mul_overflow(mul_overflow)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: result and val appear two cycles after mul_en (in CAPT).
    logic [64:0] p1, p2;
    logic        v1, v2;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1 <= '0; p2 <= '0; v1 <= 1'b0; v2 <= 1'b0;
        end else begin
            p1 <= {33'd0, mul_op1} * {33'd0, mul_op2};
            v1 <= mul_en;
            p2 <= p1;
            v2 <= v1;
        end
    end
    assign mul_res      = p2;
    assign mul_val      = v2;
    assign mul_overflow = |p2[64:32];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_valid[idx]           = 1'b1;
        req_op1[idx*32 +: 32]    = a;
        req_op2[idx*32 +: 32]    = b;
    endtask

    task automatic wait_grant(input string nm, input int idx);
        int waited;
        waited = 0;
        #1;
        while (req_ready == '0 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check({nm, " grant"}, 128'(req_ready), 128'(1 << idx));
    endtask

    task automatic do_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [64:0] exp_res, input logic exp_ovf, input string nm);
        @(negedge clk);
        req_valid  = '0;
        resp_ready = 1'b1;
        set_req(idx, a, b);
        wait_grant(nm, idx);
        @(negedge clk); req_valid = '0; #1;
        check({nm, " issue"}, {mul_en, mul_op1, mul_op2}, {1'b1, a, b});
        @(negedge clk); #1;
        check({nm, " wait"}, {mul_en, resp_valid}, 2'b00);
        @(negedge clk); #1;
        check({nm, " capt"}, 128'(resp_valid), 128'(0));
        @(negedge clk); #1;
        check({nm, " resp"}, {resp_valid, resp_id, resp_res, resp_ovf},
              {1'b1, 2'(idx), exp_res, exp_ovf});
        @(negedge clk); #1;
        check({nm, " idle"}, 128'(resp_valid), 128'(0));
    endtask

    task automatic check_zero(input string nm);
        check({nm, " ctl"}, {req_ready, resp_valid, resp_id, resp_ovf, mul_en}, '0);
        check({nm, " data"}, {resp_res, mul_op1, mul_op2}, '0);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [64:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[5];
    int   order[5];

    initial begin
        vecs[0] = '{0, 32'd3,          32'd5,          65'd15,                     1'b0};
        vecs[1] = '{2, 32'h0001_0000,  32'h0001_0000,  65'h1_0000_0000,            OVF_EXP};
        vecs[2] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  65'hFFFF_FFFE_0000_0001,    OVF_EXP};
        vecs[3] = '{3, 32'd0,          32'h1234_5678,  65'd0,                      1'b0};
        vecs[4] = '{2, 32'h0000_1234,  32'h0000_0010,  65'h1_2340,                 1'b0};
        order   = '{0, 1, 2, 3, 0};

        reset = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk); reset = 1'b1;

        for (int v = 0; v < 5; v++)
            do_txn(vecs[v].idx, vecs[v].op1, vecs[v].op2, vecs[v].res, vecs[v].ovf,
                   $sformatf("vec%0d", v));

        // Round robin with all requesters held valid from pointer 0.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'd10);
        resp_ready = 1'b1;
        begin
            int g, last;
            g = 0; last = 0;
            for (int c = 0; c < 40 && g < 5; c++) begin
                #1;
                if (req_ready != '0) begin
                    check($sformatf("rr grant%0d", g), 128'(req_ready), 128'(1 << order[g]));
                    if (g > 0) check($sformatf("rr spacing%0d", g), 128'(c - last), 128'(5));
                    last = c;
                    g++;
                end
                @(negedge clk);
            end
            check("rr count", 128'(g), 128'(5));
        end
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Backpressure: hold RESP for 10 cycles while another request waits.
        req_valid = '0; resp_ready = 1'b0;
        set_req(3, 32'd7, 32'd6);
        wait_grant("bp", 3);
        @(negedge clk); req_valid = '0; set_req(0, 32'd2, 32'd2);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 check($sformatf("bp hold%0d", i), {resp_valid, resp_id, resp_res, req_ready},
                     {1'b1, 2'd3, 65'd42, 4'd0});
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk); #1;
        check("bp release", {resp_valid, req_ready}, {1'b0, 4'b0001});
        @(negedge clk); req_valid = '0;
        begin
            int w;
            w = 0;
            #1;
            while (!resp_valid && w < 10) begin @(negedge clk); #1; w++; end
            check("bp next", {resp_valid, resp_id, resp_res}, {1'b1, 2'd0, 65'd4});
        end
        @(negedge clk);

        // Reset while the multiplier is in flight (WAIT state).
        req_valid = '0; resp_ready = 1'b1;
        set_req(1, 32'd9, 32'd9);
        wait_grant("rstw", 1);
        @(negedge clk); req_valid = '0;
        @(negedge clk); reset = 1'b0;
        #1 check_zero("rst in wait");
        @(negedge clk); reset = 1'b1;
        do_txn(1, 32'h0000_FFFF, 32'h0001_0000, 65'hFFFF_0000, 1'b0, "post rst");
        check("err flag", 128'(dut.err), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter: IDW, default $clog2(NREQ), width of the response ID.
REQ-003 Ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Ports: reset  input  1  asynchronous, active-low reset.
REQ-005 Ports: req_valid  input  NREQ  per-requester request pending.
REQ-006 Ports: req_ready  output  NREQ  per-requester accept strobe.
REQ-007 Ports: req_op1  input  32*NREQ  packed operand 1; slice i is requester i.
REQ-008 Ports: req_op2  input  32*NREQ  packed operand 2; slice i is requester i.
REQ-009 Ports: resp_valid  output  1  response available.
REQ-010 Ports: resp_ready  input  1  consumer accepts the response.
REQ-011 Ports: resp_id  output  IDW  index of the requester owning the response.
REQ-012 Ports: resp_res  output  65  product.
REQ-013 Ports: resp_ovf  output  1  product exceeds 32 bits.
REQ-014 Ports: mul_en, mul_op1[31:0], mul_op2[31:0]  outputs  drive the multiplier's en, op1 and op2.
REQ-015 Ports: mul_res[64:0], mul_val, mul_overflow  inputs  from the multiplier's res, val and overflow.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, CAPT and RESP.
REQ-017 IDLE: if any req_valid is high, the block SHALL grant one requester round-robin, starting the search at the pointer and ascending modulo NREQ.
REQ-018 req_ready[g] SHALL be combinational, high only in IDLE for the granted g, and one-hot or zero.
REQ-019 On the grant edge the block SHALL register op1, op2 and the ID, set the pointer to g+1 mod NREQ, and go to ISSUE.
REQ-020 ISSUE: mul_en SHALL be 1 for exactly one cycle, with the registered operands on mul_op1/mul_op2; next state WAIT.
REQ-021 WAIT SHALL last one cycle and then go to CAPT, regardless of mul_val.
REQ-022 CAPT: the block SHALL register mul_res and mul_overflow and go to RESP; if mul_val is 0 in CAPT, it SHALL set a sticky err flag, visible only in simulation.
REQ-023 RESP: resp_valid=1, with resp_id, resp_res and resp_ovf held stable until a cycle where resp_ready=1; then it SHALL go to IDLE.
REQ-024 Latency: with the grant at cycle A, mul_en SHALL be high at A+1, capture SHALL happen at A+3 and resp_valid SHALL go high at A+4.
REQ-025 Maximum throughput SHALL be one operation per 5 cycles with resp_ready held at 1.
REQ-026 Only one operation SHALL be outstanding; req_ready SHALL be 0 in all states except IDLE.
REQ-027 mul_en SHALL be 0 in every state except ISSUE; mul_op1/mul_op2 SHALL hold the last registered operands.
REQ-028 req_valid dropping without a grant is legal; that requester SHALL lose no state.
REQ-029 A requester whose req_valid stays high SHALL be granted within NREQ grants.

Reset
REQ-030 While reset=0: state=IDLE, pointer=0, req_ready=0, resp_valid=0, resp_id=0, resp_res=0, resp_ovf=0, mul_en=0, mul_op1=0, mul_op2=0.
REQ-031 Reset mid-operation SHALL abandon the operation with no response; at least one IDLE cycle before ISSUE guarantees the multiplier's internal toggle has cleared.

Configuration
REQ-032 With MUL_ARB_OVF_EN defined, resp_ovf SHALL be the captured mul_overflow.
REQ-033 Without MUL_ARB_OVF_EN, resp_ovf SHALL be tied to 0 and mul_overflow SHALL be unused; the port list SHALL be unchanged.

Verification
REQ-034 Single request: req0 with 3 and 5, resp_ready=1 -> resp_valid at A+4, resp_id=0, resp_res=15, resp_ovf=0.
REQ-035 All four requesters valid continuously, pointer=0 -> grant order 0,1,2,3,0, one grant per 5 cycles.
REQ-036 req2 with 0x10000 x 0x10000 -> resp_res=0x1_0000_0000; resp_ovf=1 with MUL_ARB_OVF_EN defined, 0 without it.
REQ-037 Backpressure: resp_ready=0 for 10 cycles during RESP -> response held stable, req_ready stays 0, resp_ready=1 -> IDLE next cycle.
REQ-038 reset=0 asserted in WAIT -> all outputs 0 immediately; after release, req1 with 0xFFFF x 0x10000 -> resp_res=0xFFFF0000 with err clear.
